// File: rtl/alu_op_sequencer_if.sv
// Purpose : bundles the request, ALU-facing and result signals of alu_op_sequencer.
// Latency : n/a (wires only).
// Backpressure: none; a requester waits for busy low and then samples the done pulse.
//
// Signals:
//   start, op, a, b        request from the control unit (sampled only while idle)
//   alu_a, alu_b           latched operands presented to the ALU
//   alu_control            one-hot ALU control word (non-zero only during EXEC)
//   alu_c                  combinational ALU result (2*WIDTH bits)
//   hi, lo                 result registers
//   busy, done             status; done is a one-cycle pulse
//   div_by_zero, illegal_op error flags, valid with done, held until next accept
//
// Modports:
//   master : the sequencer's environment (control unit plus ALU)
//   slave  : the sequencer itself
interface alu_op_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 13
);
  logic                  start;
  logic [CTRL_W-1:0]     op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [CTRL_W-1:0]     alu_control;
  logic [2*WIDTH-1:0]    alu_c;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic                  illegal_op;

  modport master (
    output start, op, a, b, alu_c,
    input  alu_a, alu_b, alu_control, hi, lo, busy, done, div_by_zero, illegal_op
  );

  modport slave (
    input  start, op, a, b, alu_c,
    output alu_a, alu_b, alu_control, hi, lo, busy, done, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose : multi-cycle sequencer between control unit and 32-bit ALU; holds operands and
//           the one-hot control word, captures the 64-bit ALU result into hi/lo, and runs
//           DIV itself with an iterative restoring divider.
// Latency : non-DIV / divide-by-zero / illegal op: done 1 cycle after accept, idle after 2;
//           DIV with b!=0: done 33 cycles after accept, idle after 34.
// Backpressure: one operation at a time; start is ignored whenever busy is high (no queue).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_op_sequencer_if.slave (request, ALU drive/return, results, status)
//
// Build option: define ALU_SEQ_SIGNED_DIV_EN for two's-complement DIV (divider runs on
// magnitudes, quotient negated when operand signs differ, remainder follows the dividend
// sign). Without it DIV is unsigned and the FIX cycle is still spent.
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int CTRL_W  = 13,
  parameter int DIV_BIT = 5
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // What the FIX cycle has to do with the request that brought us there.
  typedef enum logic [1:0] {
    FIX_DIV = 2'd0,
    FIX_DBZ = 2'd1,
    FIX_ILL = 2'd2
  } fix_t;

  state_t                r_state;
  fix_t                  r_fix;

  logic [WIDTH-1:0]      r_alu_a;
  logic [WIDTH-1:0]      r_alu_b;
  logic [CTRL_W-1:0]     r_alu_control;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dbz;
  logic                  r_ill;

  // Divider datapath: partial remainder, dividend/quotient shift register, divisor, count.
  logic [WIDTH:0]        r_rem;
  logic [WIDTH-1:0]      r_quo;
  logic [WIDTH-1:0]      r_dvs;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_op_legal;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [WIDTH-1:0]      w_a_mag;
  logic [WIDTH-1:0]      w_b_mag;
  logic [WIDTH+1:0]      w_shift;
  logic                  w_fits;
  logic [WIDTH:0]        w_diff;
  logic [WIDTH:0]        w_rem_nxt;
  logic [WIDTH-1:0]      w_quo_fix;
  logic [WIDTH-1:0]      w_rem_fix;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_op_legal = (bus.op != '0) && ((bus.op & (bus.op - CTRL_W'(1))) == '0);

`ifdef ALU_SEQ_SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = bus.a[WIDTH-1];
  assign w_b_neg = bus.b[WIDTH-1];

  // 0x8000_0000 has no positive counterpart, but its magnitude is still correct as an
  // unsigned value, so the most-negative operand needs no special case.
  assign w_quo_fix = r_neg_q ? (-r_quo) : r_quo;
  assign w_rem_fix = r_neg_r ? (-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
`else
  assign w_a_neg   = 1'b0;
  assign w_b_neg   = 1'b0;
  assign w_quo_fix = r_quo;
  assign w_rem_fix = r_rem[WIDTH-1:0];
`endif

  assign w_a_mag = w_a_neg ? (-bus.a) : bus.a;
  assign w_b_mag = w_b_neg ? (-bus.b) : bus.b;

  // One restoring step: bring in the next dividend bit (MSB of the shift register) and
  // subtract the divisor if it fits. The comparison is done on the full shifted value so
  // that the subtraction itself never has to represent a negative result.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_fits    = (w_shift >= {2'b00, r_dvs});
  assign w_diff    = w_shift[WIDTH:0] - {1'b0, r_dvs};
  assign w_rem_nxt = w_fits ? w_diff : w_shift[WIDTH:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_fix         <= FIX_DIV;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_control <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_dbz         <= 1'b0;
      r_ill         <= 1'b0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_alu_a <= bus.a;
            r_alu_b <= bus.b;
            r_dbz   <= 1'b0;
            r_ill   <= 1'b0;
            r_busy  <= 1'b1;
            // Divider is primed on every accept; it is only clocked in ST_DIV.
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_cnt   <= '0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
`endif
            if (!w_op_legal) begin
              r_fix   <= FIX_ILL;
              r_state <= ST_FIX;
            end else if (bus.op[DIV_BIT]) begin
              if (bus.b == '0) begin
                r_fix   <= FIX_DBZ;
                r_state <= ST_FIX;
              end else begin
                r_fix   <= FIX_DIV;
                r_state <= ST_DIV;
              end
            end else begin
              // Control word goes out registered so the ALU sees it for the whole EXEC cycle.
              r_alu_control <= bus.op;
              r_state       <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          r_hi          <= bus.alu_c[2*WIDTH-1:WIDTH];
          r_lo          <= bus.alu_c[WIDTH-1:0];
          r_alu_control <= '0;
          r_done        <= 1'b1;
          r_state       <= ST_DONE;
        end

        ST_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_FIX;
          end
        end

        ST_FIX: begin
          case (r_fix)
            FIX_DIV: begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
            FIX_DBZ: begin
              r_hi  <= r_alu_a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end
            default: begin
              // Illegal op: results untouched, only the flag is raised.
              r_ill <= 1'b1;
            end
          endcase
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_control = r_alu_control;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.illegal_op  = r_ill;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int W  = 32;
  localparam int CW = 13;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  // Reference state: what hi/lo/flags should hold after the last completed request.
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic         m_dbz;
  logic         m_ill;

  alu_op_sequencer_if #(.WIDTH(W), .CTRL_W(CW)) bus ();

  alu_op_sequencer #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU. With no valid control word it returns garbage, so a
  // capture at the wrong moment is visible in hi/lo.
  function automatic logic [63:0] alu_fn(input logic [CW-1:0] c, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (c)
      13'h0001: return {32'h0, x & y};
      13'h0002: return {32'h0, x | y};
      13'h0004: return {32'h0, x ^ y};
      13'h0008: return {32'h0, x + y};
      13'h0010: return 64'(x) * 64'(y);
      13'h0040: return {32'h0, x - y};
      13'h0080: return {32'h0, x << y[4:0]};
      13'h0100: return {32'h0, x >> y[4:0]};
      13'h0200: return {63'h0, (x < y)};
      13'h0400: return {y, x};
      13'h0800: return {32'h0, ~(x | y)};
      13'h1000: return {32'h0, ~x};
      default:  return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  always_comb bus.alu_c = alu_fn(bus.alu_control, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one request, straight from the operation rules.
  task automatic model_op(input logic [CW-1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
    logic [63:0] r;
    longint sa, sb, q, rm;
    if ($countones(op) != 1) begin
      m_ill = 1'b1;
      m_dbz = 1'b0;
      lat   = 1;
    end else if (op == 13'h0020) begin
      m_ill = 1'b0;
      if (b == '0) begin
        m_lo  = 32'hFFFF_FFFF;
        m_hi  = a;
        m_dbz = 1'b1;
        lat   = 1;
      end else begin
`ifdef ALU_SEQ_SIGNED_DIV_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        q    = sa / sb;
        rm   = sa % sb;
        m_lo = q[31:0];
        m_hi = rm[31:0];
        m_dbz = 1'b0;
        lat  = 33;
      end
    end else begin
      r     = alu_fn(op, a, b);
      m_hi  = r[63:32];
      m_lo  = r[31:0];
      m_ill = 1'b0;
      m_dbz = 1'b0;
      lat   = 1;
    end
  endtask

  // Issue one request and follow it to idle. inj_k > 0 pulses a stray start before edge inj_k.
  task automatic run_op(input string tag, input logic [CW-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj_k);
    int   lat;
    int   k;
    bit   seen;
    bit   exec;
    exec = ($countones(op) == 1) && (op != 13'h0020);
    @(negedge clk);
    chk({tag, ":idle"}, bus.busy, 0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    model_op(op, a, b, lat);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = CW'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    chk({tag, ":busy"}, bus.busy, 1);
    chk({tag, ":ctl"}, bus.alu_control, exec ? op : 13'h0);
    k    = 1;
    seen = 0;
    while (k <= 40 && !seen) begin
      bus.start = (k == inj_k);
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1;
      else k++;
    end
    chk({tag, ":lat"}, k, lat);
    chk({tag, ":hi"}, bus.hi, m_hi);
    chk({tag, ":lo"}, bus.lo, m_lo);
    chk({tag, ":dbz"}, bus.div_by_zero, m_dbz);
    chk({tag, ":ill"}, bus.illegal_op, m_ill);
    chk({tag, ":ctl0"}, bus.alu_control, 0);
    @(negedge clk);
    chk({tag, ":pulse"}, bus.done, 0);
    chk({tag, ":idle2"}, bus.busy, 0);
    chk({tag, ":hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    chk({tag, ":flags"}, {bus.div_by_zero, bus.illegal_op}, {m_dbz, m_ill});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] rop;
    logic [W-1:0]  ra, rb;
    int            sel;
    checks    = 0;
    errors    = 0;
    m_hi      = '0;
    m_lo      = '0;
    m_dbz     = 1'b0;
    m_ill     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst:hi", bus.hi, 0);
    chk("rst:lo", bus.lo, 0);
    chk("rst:busy", bus.busy, 0);
    chk("rst:done", bus.done, 0);
    chk("rst:flags", {bus.div_by_zero, bus.illegal_op}, 0);
    chk("rst:ops", {bus.alu_a, bus.alu_b, bus.alu_control}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("and", 13'h001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("mul", 13'h010, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("div_m7_2", 13'h020, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("dbz", 13'h020, 32'h1234_5678, 32'h0000_0000, 0);
    run_op("illegal", 13'h003, 32'h1111_1111, 32'h2222_2222, 0);
    run_op("illegal0", 13'h000, 32'h3333_3333, 32'h4444_4444, 0);
    run_op("div_inject", 13'h020, 32'd100, 32'd7, 5);
    run_op("div_minmax", 13'h020, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_big", 13'h020, 32'hFFFF_FFFF, 32'h0000_0003, 0);

    // Reset during iteration 10 of a division
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 13'h020;
    bus.a     = 32'h7654_3210;
    bus.b     = 32'h0000_0013;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst:hilo", {bus.hi, bus.lo}, 0);
    chk("mid_rst:busy", bus.busy, 0);
    chk("mid_rst:done", bus.done, 0);
    chk("mid_rst:ops", {bus.alu_a, bus.alu_b, bus.alu_control}, 0);
    chk("mid_rst:flags", {bus.div_by_zero, bus.illegal_op}, 0);
    m_hi  = '0;
    m_lo  = '0;
    m_dbz = 1'b0;
    m_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 13'h008, 32'h0000_FFFF, 32'h0000_0001, 0);
    run_op("post_rst_div", 13'h020, 32'h7654_3210, 32'h0000_0013, 0);

    // Randomized requests against the reference model
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) begin
        rop = CW'($urandom);
      end else if (sel <= 3) begin
        rop = 13'h020;
        if ($urandom_range(0, 3) == 0) rb = '0;
        else if ($urandom_range(0, 1) == 0) rb = rb >> $urandom_range(0, 31);
      end else begin
        rop = CW'(1) << $urandom_range(0, 12);
      end
      run_op("rand", rop, ra, rb, (sel == 2) ? int'($urandom_range(1, 30)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle sequencer that sits between the control unit and the 32-bit ALU. It accepts one operation per start/done handshake and holds the operands and the one-hot control word stable for the ALU. It captures the 64-bit ALU result into HI/LO registers. It executes DIV itself with an iterative restoring divider, because the ALU has no divide path.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each WIDTH bits.
- `CTRL_W`, 13: one-hot ALU control width. Bit 5 is DIV.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  CTRL_W: one-hot operation, same encoding as the ALU control word.
- `a`, `b`  in  WIDTH: operands, sampled with `start`.
- `alu_a`, `alu_b`  out  WIDTH: latched operands to the ALU.
- `alu_control`  out  CTRL_W: equals latched op in EXEC, otherwise 0.
- `alu_c`  in  2*WIDTH: ALU result.
- `hi`, `lo`  out  WIDTH: result registers.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when `hi`/`lo` are valid.
- `div_by_zero`  out  1: set with `done` for a DIV where `b == 0`.
- `illegal_op`  out  1: set with `done` when `op` is not exactly one-hot.

## Operation
- States:
  - IDLE → EXEC (non-DIV, legal op).
  - IDLE → DIV (DIV, b≠0).
  - IDLE → FIX (DIV, b==0, or illegal op).
  - EXEC → DONE.
  - DIV → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE.
- Accepting a request (`start` in IDLE):
  - latch `a`, `b`, `op` into `alu_a`, `alu_b`, and an internal op register;
  - clear `div_by_zero` and `illegal_op`.
- `start` in any state other than IDLE is ignored. No queuing.
- EXEC:
  - `alu_control` = latched op for the full cycle;
  - `{hi,lo} <= alu_c` at the EXEC→DONE edge.
- DIV uses an internal restoring divider (33-bit partial remainder, 32-bit quotient, 6-bit counter), one quotient bit per cycle, MSB first. `alu_control` = 0 during DIV.
- FIX, normal DIV:
  - `lo` = quotient, `hi` = remainder, with sign correction per Configuration.
- FIX, b==0:
  - `lo` = 32'hFFFF_FFFF, `hi` = `a`, `div_by_zero` = 1.
- FIX, illegal op:
  - `hi`/`lo` unchanged, `illegal_op` = 1.
- DONE:
  - `done` = 1 for exactly one cycle;
  - error flags hold until the next accepted `start`.
- Reset (asynchronous, any state, including mid-DIV):
  - state = IDLE;
  - `hi`, `lo`, `alu_a`, `alu_b`, `alu_control`, divider registers = 0;
  - `busy`, `done`, `div_by_zero`, `illegal_op` = 0.
- A partially computed division is discarded on reset. `hi`/`lo` never show intermediate divider values.

## Timing
- Edge 0 is the edge that samples `start`=1 in IDLE.
- Non-DIV op:
  - EXEC between edges 0 and 1;
  - `hi`/`lo` written at edge 1;
  - `done` high between edges 1 and 2;
  - latency is 2 cycles start→IDLE.
- DIV, b≠0:
  - iterations at edges 1..32;
  - FIX result written at edge 33;
  - `done` high between edges 33 and 34.
- DIV with b==0, or illegal op: results/flags written at edge 1; `done` high between edges 1 and 2.
- `busy` rises after edge 0 and falls at the edge that leaves DONE.
- The earliest next accept is the edge after `done` falls, i.e. the first edge in IDLE.
- `alu_c` must settle within one cycle of `alu_control` becoming valid (combinational ALU).
- All outputs are registered; none depends combinationally on inputs.

## Configuration
- `ALU_SEQ_SIGNED_DIV_EN` defined: DIV is two's-complement.
  - The divider runs on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x8000_0000 / 0xFFFF_FFFF gives `lo` = 0x8000_0000, `hi` = 0.
- Undefined: DIV is unsigned. No sign handling, and the FIX state still costs one cycle.

## Test plan
- AND: a=0xF0F0_F0F0, b=0xFF00_FF00, op=13'h001 → `lo`=0xF000_F000, `hi`=0, `done` pulse between edges 1 and 2.
- MUL: a=0x0001_0000, b=0x0001_0000, op=13'h010 → `hi`=0x0000_0001, `lo`=0; `alu_control`=13'h010 only during EXEC.
- DIV: a=-7, b=2, op=13'h020.
  - Signed build: `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF.
  - Unsigned build: `lo`=0x7FFF_FFFC, `hi`=1.
  - Both builds: `done` between edges 33 and 34.
- Divide by zero: a=0x1234_5678, b=0 → `lo`=0xFFFF_FFFF, `hi`=0x1234_5678, `div_by_zero`=1, `done` between edges 1 and 2.
- Illegal/busy: op=13'h003 → `illegal_op`=1, `hi`/`lo` unchanged. A second `start` pulsed during a DIV is ignored, and the original result is intact.
- Reset mid-DIV: deassert `rst_n` at iteration 10 → all outputs 0 immediately, state IDLE; the next request executes normally.
